// File: rtl/mdu_iter_pkg.sv
// rtl/mdu_iter_pkg.sv - shared defines: ALU/MDU opcodes and MDU FSM state encodings
package mdu_iter_pkg;

  typedef enum logic [3:0] {
    ALUOP_ADD, ALUOP_SUB, ALUOP_AND, ALUOP_OR,
    ALUOP_XOR, ALUOP_SLT, ALUOP_SLTU, ALUOP_MDU
  } aluop_e;

  localparam logic [2:0] MDU_OP_MULT  = 3'd0;
  localparam logic [2:0] MDU_OP_MULTU = 3'd1;
  localparam logic [2:0] MDU_OP_DIV   = 3'd2;
  localparam logic [2:0] MDU_OP_DIVU  = 3'd3;
  localparam logic [2:0] MDU_OP_MTHI  = 3'd4;
  localparam logic [2:0] MDU_OP_MTLO  = 3'd5;

  localparam logic [1:0] ST_IDLE = 2'd0;
  localparam logic [1:0] ST_RUN  = 2'd1;
  localparam logic [1:0] ST_FIX  = 2'd2;

endpackage

// File: rtl/mdu_div_core.sv
// rtl/mdu_div_core.sv - one combinational restoring-divide step on unsigned magnitudes
module mdu_div_core #(
  parameter int WIDTH = 32
) (
  input  logic [WIDTH-1:0] i_rem,
  input  logic [WIDTH-1:0] i_quo,
  input  logic [WIDTH-1:0] i_dvs,
  output logic [WIDTH-1:0] o_rem,
  output logic [WIDTH-1:0] o_quo
);

  logic [WIDTH:0] w_shift;
  logic [WIDTH:0] w_diff;
  logic           w_ge;

  // i_quo shifts the dividend out at the top while quotient bits enter at the bottom
  assign w_shift = {i_rem, i_quo[WIDTH-1]};
  assign w_diff  = w_shift - {1'b0, i_dvs};
  assign w_ge    = ~w_diff[WIDTH];
  assign o_rem   = w_ge ? w_diff[WIDTH-1:0] : w_shift[WIDTH-1:0];
  assign o_quo   = {i_quo[WIDTH-2:0], w_ge};

endmodule

// File: rtl/mdu_iter.sv
// rtl/mdu_iter.sv - iterative multiply/divide unit with HI/LO registers
// Define MDU_FAST_MUL_EN for single-cycle MULT/MULTU; divides stay iterative.
module mdu_iter
  import mdu_iter_pkg::*;
#(
  parameter int WIDTH   = 32,
  parameter int MDU_OPW = 3
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               start_i,
  input  logic [MDU_OPW-1:0] op_i,
  input  logic [WIDTH-1:0]   src0_i,
  input  logic [WIDTH-1:0]   src1_i,
  input  logic               cancel_i,
  output logic [WIDTH-1:0]   hi_o,
  output logic [WIDTH-1:0]   lo_o,
  output logic               busy_o,
  output logic               done_o,
  output logic               dz_o
);

  localparam int CW = $clog2(WIDTH);

  logic [1:0]         r_state;
  logic [CW-1:0]      r_cnt;
  logic [WIDTH-1:0]   r_hi, r_lo, r_a, r_b, r_m;
  logic               r_is_div, r_neg_q, r_neg_r, r_dz, r_done, r_dz_flag;

  logic               w_busy, w_accept, w_iter, w_signed, w_neg0, w_neg1;
  logic               w_op_mult, w_op_multu, w_op_div, w_op_divu, w_op_mthi, w_op_mtlo;
  logic [WIDTH-1:0]   w_mag0, w_mag1, w_div_rem, w_div_quo, w_q_fix, w_r_fix;
  logic [WIDTH:0]     w_mul_sum;
  logic [2*WIDTH-1:0] w_prod_fix;

  assign w_busy     = (r_state != ST_IDLE);
  assign w_accept   = start_i & ~w_busy & ~cancel_i;
  assign w_op_mult  = (op_i == MDU_OPW'(MDU_OP_MULT));
  assign w_op_multu = (op_i == MDU_OPW'(MDU_OP_MULTU));
  assign w_op_div   = (op_i == MDU_OPW'(MDU_OP_DIV));
  assign w_op_divu  = (op_i == MDU_OPW'(MDU_OP_DIVU));
  assign w_op_mthi  = (op_i == MDU_OPW'(MDU_OP_MTHI));
  assign w_op_mtlo  = (op_i == MDU_OPW'(MDU_OP_MTLO));
  assign w_signed   = w_op_mult | w_op_div;
  assign w_neg0     = w_signed & src0_i[WIDTH-1];
  assign w_neg1     = w_signed & src1_i[WIDTH-1];
  assign w_mag0     = w_neg0 ? -src0_i : src0_i;
  assign w_mag1     = w_neg1 ? -src1_i : src1_i;

`ifdef MDU_FAST_MUL_EN
  logic [2*WIDTH-1:0] w_fast_prod;
  assign w_fast_prod = {{WIDTH{w_neg0}}, src0_i} * {{WIDTH{w_neg1}}, src1_i};
  assign w_iter      = w_op_div | w_op_divu;
`else
  assign w_iter      = w_op_mult | w_op_multu | w_op_div | w_op_divu;
`endif

  // Shift-add: {r_a, r_b} is the running product, the multiplier drains out of r_b
  assign w_mul_sum  = {1'b0, r_a} + {1'b0, (r_b[0] ? r_m : {WIDTH{1'b0}})};

  mdu_div_core #(.WIDTH(WIDTH)) u_div_core (
    .i_rem (r_a),
    .i_quo (r_b),
    .i_dvs (r_m),
    .o_rem (w_div_rem),
    .o_quo (w_div_quo)
  );

  assign w_q_fix    = r_neg_q ? -r_b : r_b;
  assign w_r_fix    = r_neg_r ? -r_a : r_a;
  assign w_prod_fix = r_neg_q ? -{r_a, r_b} : {r_a, r_b};

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state   <= ST_IDLE;
      r_cnt     <= '0;
      r_hi      <= '0;
      r_lo      <= '0;
      r_a       <= '0;
      r_b       <= '0;
      r_m       <= '0;
      r_is_div  <= 1'b0;
      r_neg_q   <= 1'b0;
      r_neg_r   <= 1'b0;
      r_dz      <= 1'b0;
      r_done    <= 1'b0;
      r_dz_flag <= 1'b0;
    end else begin
      r_done    <= 1'b0;
      r_dz_flag <= 1'b0;
      if (w_busy && cancel_i) begin
        r_state <= ST_IDLE;
      end else begin
        case (r_state)
          ST_IDLE: if (w_accept) begin
            if (w_op_mthi) r_hi <= src0_i;
            if (w_op_mtlo) r_lo <= src0_i;
`ifdef MDU_FAST_MUL_EN
            if (w_op_mult || w_op_multu) begin
              {r_hi, r_lo} <= w_fast_prod;
              r_done       <= 1'b1;
            end
`endif
            if (w_iter) begin
              r_state  <= ST_RUN;
              r_cnt    <= '0;
              r_a      <= '0;
              r_b      <= w_mag0;
              r_m      <= w_mag1;
              r_is_div <= w_op_div | w_op_divu;
              r_neg_q  <= w_neg0 ^ w_neg1;
              r_neg_r  <= w_neg0;
              r_dz     <= (w_op_div | w_op_divu) && (src1_i == '0);
            end
          end
          ST_RUN: begin
            if (r_is_div) {r_a, r_b} <= {w_div_rem, w_div_quo};
            else          {r_a, r_b} <= {w_mul_sum, r_b[WIDTH-1:1]};
            r_cnt <= r_cnt + 1'b1;
            if (r_cnt == CW'(WIDTH-1)) r_state <= ST_FIX;
          end
          ST_FIX: begin
            // Zero divisor: magnitude remainder fixed by dividend sign reproduces src0
            if (r_is_div) begin
              r_hi      <= w_r_fix;
              r_lo      <= r_dz ? {WIDTH{1'b1}} : w_q_fix;
              r_dz_flag <= r_dz;
            end else begin
              {r_hi, r_lo} <= w_prod_fix;
            end
            r_done  <= 1'b1;
            r_state <= ST_IDLE;
          end
          default: r_state <= ST_IDLE;
        endcase
      end
    end
  end

  assign hi_o   = r_hi;
  assign lo_o   = r_lo;
  assign busy_o = w_busy;
  assign done_o = r_done;
  assign dz_o   = r_dz_flag;

endmodule

// File: tb/tb_mdu_iter.sv
// tb/tb_mdu_iter.sv - scoreboard bench for mdu_iter against an arithmetic reference model
module tb_mdu_iter;
  import mdu_iter_pkg::*;

  localparam int W = 32;
`ifdef MDU_FAST_MUL_EN
  localparam bit FAST    = 1'b1;
  localparam int MUL_LAT = 0;
`else
  localparam bit FAST    = 1'b0;
  localparam int MUL_LAT = 33;
`endif
  localparam int DIV_LAT = 33;

  logic          clk = 1'b0;
  logic          rst, start_i, cancel_i;
  logic [2:0]    op_i;
  logic [W-1:0]  src0_i, src1_i, hi_o, lo_o;
  logic          busy_o, done_o, dz_o;

  mdu_iter #(.WIDTH(W), .MDU_OPW(3)) dut (
    .clk(clk), .rst(rst), .start_i(start_i), .op_i(op_i),
    .src0_i(src0_i), .src1_i(src1_i), .cancel_i(cancel_i),
    .hi_o(hi_o), .lo_o(lo_o), .busy_o(busy_o), .done_o(done_o), .dz_o(dz_o)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [W-1:0] hi;
    logic [W-1:0] lo;
    logic         dz;
    int           cyc;
  } exp_t;

  exp_t         sb_q[$];
  int           n_cmp = 0;
  int           n_err = 0;
  int           cyc = 0;
  logic [W-1:0] m_hi = '0;
  logic [W-1:0] m_lo = '0;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h (t=%0t)", name, act, exp, $time);
    end
  endtask

  function automatic void ref_op(input logic [2:0] op, input logic [W-1:0] a, input logic [W-1:0] b,
                                 output logic [W-1:0] h, output logic [W-1:0] l, output logic dz);
    longint          sa, sb, sq, sr;
    longint unsigned ua, ub, up;
    sa = $signed(a);
    sb = $signed(b);
    ua = {32'b0, a};
    ub = {32'b0, b};
    dz = 1'b0;
    h  = '0;
    l  = '0;
    case (op)
      MDU_OP_MULT:  begin sq = sa * sb; h = sq[63:32]; l = sq[31:0]; end
      MDU_OP_MULTU: begin up = ua * ub; h = up[63:32]; l = up[31:0]; end
      MDU_OP_DIV, MDU_OP_DIVU: begin
        if (b == '0) begin
          h = a; l = '1; dz = 1'b1;
        end else if (op == MDU_OP_DIV) begin
          sq = sa / sb; sr = sa % sb; h = sr[31:0]; l = sq[31:0];
        end else begin
          up = ua / ub; h = W'(ua % ub); l = up[31:0];
        end
      end
      default: ;
    endcase
  endfunction

  task automatic issue(input logic [2:0] op, input logic [W-1:0] a, input logic [W-1:0] b, input bit track);
    logic [W-1:0] h, l;
    logic         dz;
    exp_t         e;
    bit           mul, iter;
    mul  = (op == MDU_OP_MULT) || (op == MDU_OP_MULTU);
    iter = (op == MDU_OP_DIV) || (op == MDU_OP_DIVU) || (mul && !FAST);
    op_i = op; src0_i = a; src1_i = b; start_i = 1'b1;
    if (mul || iter) begin
      ref_op(op, a, b, h, l, dz);
      if (track) begin
        e.hi = h; e.lo = l; e.dz = dz;
        e.cyc = cyc + 1 + (mul ? MUL_LAT : DIV_LAT);
        sb_q.push_back(e);
        m_hi = h; m_lo = l;
      end
    end else if (op == MDU_OP_MTHI) begin
      m_hi = a;
    end else if (op == MDU_OP_MTLO) begin
      m_lo = a;
    end
    @(negedge clk);
    start_i = 1'b0;
    check("busy_after_accept", busy_o, iter);
    if (!mul && !iter) begin
      check("hi_after_move", hi_o, m_hi);
      check("lo_after_move", lo_o, m_lo);
    end
  endtask

  // Operand inputs churn while busy; the latched operands must still win
  task automatic wait_idle(input int budget);
    int n = 0;
    while (busy_o && n < budget) begin
      src0_i = $urandom;
      src1_i = $urandom;
      op_i   = 3'($urandom_range(0, 7));
      @(negedge clk);
      n++;
    end
    check("idle_within_budget", busy_o, 0);
  endtask

  always @(negedge clk) begin : monitor
    exp_t e;
    if (done_o) begin
      if (sb_q.size() == 0) begin
        check("unexpected_done", done_o, 0);
      end else begin
        e = sb_q.pop_front();
        check("done_hi", hi_o, e.hi);
        check("done_lo", lo_o, e.lo);
        check("done_dz", dz_o, e.dz);
        check("done_busy", busy_o, 0);
        check("done_latency", cyc, e.cyc);
      end
    end
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  logic [2:0]   d_op [7] = '{MDU_OP_MULT, MDU_OP_DIV, MDU_OP_DIVU, MDU_OP_DIVU, MDU_OP_DIV, MDU_OP_MULTU, MDU_OP_DIV};
  logic [W-1:0] d_a  [7] = '{32'hFFFFFFFE, 32'hFFFFFFF9, 32'd100, 32'd5, 32'h80000000, 32'hFFFFFFFF, 32'hFFFFFFFB};
  logic [W-1:0] d_b  [7] = '{32'd3, 32'd2, 32'd7, 32'd0, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'd0};

  initial begin
    logic [2:0]   op;
    logic [W-1:0] a, b;
    rst = 1'b1; start_i = 1'b0; cancel_i = 1'b0; op_i = '0; src0_i = '0; src1_i = '0;
    repeat (3) @(negedge clk);
    check("reset_hi", hi_o, 0);
    check("reset_lo", lo_o, 0);
    check("reset_busy", busy_o, 0);
    check("reset_done", done_o, 0);
    check("reset_dz", dz_o, 0);
    rst = 1'b0;
    @(negedge clk);

    for (int i = 0; i < 7; i++) begin
      issue(d_op[i], d_a[i], d_b[i], 1'b1);
      wait_idle(100);
    end

    issue(MDU_OP_MTHI, 32'h1234, 32'h0, 1'b1);
    issue(MDU_OP_MTLO, 32'h5678, 32'h0, 1'b1);
    check("mt_hi_kept", hi_o, 32'h1234);

    // Cancel mid-divide, with a second start ignored while busy
    issue(MDU_OP_DIVU, 32'd1000, 32'd7, 1'b0);
    repeat (8) @(negedge clk);
    op_i = MDU_OP_DIVU; src0_i = 32'd50; src1_i = 32'd3; start_i = 1'b1;
    @(negedge clk);
    start_i = 1'b0;
    check("busy_before_cancel", busy_o, 1);
    cancel_i = 1'b1;
    @(negedge clk);
    cancel_i = 1'b0;
    check("busy_after_cancel", busy_o, 0);
    check("hi_after_cancel", hi_o, m_hi);
    check("lo_after_cancel", lo_o, m_lo);
    repeat (40) @(negedge clk);
    check("hi_long_after_cancel", hi_o, 32'h1234);
    check("lo_long_after_cancel", lo_o, 32'h5678);

    issue(3'd6, 32'hFFFF, 32'd1, 1'b0);
    issue(3'd7, 32'hAAAA, 32'd2, 1'b0);
    repeat (40) @(negedge clk);

    for (int i = 0; i < 40; i++) begin
      op = 3'($urandom_range(0, 5));
      a  = $urandom;
      b  = $urandom;
      case ($urandom_range(0, 7))
        0: b = '0;
        1: begin a = 32'h80000000; b = '1; end
        2: b = W'($urandom_range(1, 15));
        default: ;
      endcase
      issue(op, a, b, 1'b1);
      wait_idle(100);
    end

    // Reset mid-multiply, asserted together with cancel and start
    issue(MDU_OP_MULT, 32'h12345678, 32'h9ABCDEF0, 1'b1);
    repeat (5) @(negedge clk);
    rst = 1'b1; cancel_i = 1'b1; start_i = 1'b1; op_i = MDU_OP_MTHI; src0_i = 32'hABCD;
    @(negedge clk);
    sb_q.delete();
    m_hi = '0; m_lo = '0;
    check("rst_mid_hi", hi_o, 0);
    check("rst_mid_lo", lo_o, 0);
    check("rst_mid_busy", busy_o, 0);
    check("rst_mid_done", done_o, 0);
    check("rst_mid_dz", dz_o, 0);
    rst = 1'b0; cancel_i = 1'b0; start_i = 1'b0;
    repeat (40) @(negedge clk);
    check("post_rst_hi", hi_o, 0);

    check("scoreboard_drained", sb_q.size(), 0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
